// File: rtl/trig_pkg.sv
// Shared encodings for the trigger sequencer.
//   edge_mode_e : per-bit qualifier applied to the probe history
//   logic_op_e  : per-stage reduction over the enabled bits
//   state_e     : sequencer FSM states
//   STAGE_IDX_W : width of the stage index and num_stages ports
package trig_pkg;

  localparam int unsigned STAGE_IDX_W = 4;

  typedef enum logic [2:0] {
    EM_OFF  = 3'd0,
    EM_LOW  = 3'd1,
    EM_HIGH = 3'd2,
    EM_RISE = 3'd3,
    EM_FALL = 3'd4,
    EM_ANY  = 3'd5
  } edge_mode_e;

  typedef enum logic [1:0] {
    LG_AND  = 2'd0,
    LG_OR   = 2'd1,
    LG_NAND = 2'd2,
    LG_NOR  = 2'd3
  } logic_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEQ  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/trig_stage_eval.sv
// Combinational match of one trigger stage against the current probe sample.
//   d_q      : current sample
//   d_p      : previous sample (edge reference)
//   mode     : 3-bit edge_mode_e per probe bit
//   logic_op : logic_op_e reduction over the enabled bits
//   match    : stage condition true for this sample
module trig_stage_eval
  import trig_pkg::*;
#(
  parameter int unsigned DET_NUM = 19
) (
  input  logic [DET_NUM-1:0]   d_q,
  input  logic [DET_NUM-1:0]   d_p,
  input  logic [DET_NUM*3-1:0] mode,
  input  logic [1:0]           logic_op,
  output logic                 match
);

  logic [DET_NUM-1:0] en;
  logic [DET_NUM-1:0] hit;
  logic               all_hit;
  logic               any_hit;

  always_comb begin
    en  = '0;
    hit = '0;
    for (int unsigned b = 0; b < DET_NUM; b++) begin
      // Encodings 6 and 7 are unused and behave like "off".
      case (edge_mode_e'(mode[b*3 +: 3]))
        EM_LOW:  begin en[b] = 1'b1; hit[b] = ~d_q[b];            end
        EM_HIGH: begin en[b] = 1'b1; hit[b] =  d_q[b];            end
        EM_RISE: begin en[b] = 1'b1; hit[b] =  d_q[b] & ~d_p[b];  end
        EM_FALL: begin en[b] = 1'b1; hit[b] = ~d_q[b] &  d_p[b];  end
        EM_ANY:  begin en[b] = 1'b1; hit[b] =  d_q[b] ^  d_p[b];  end
        default: ;
      endcase
    end
    // Disabled bits are neutral: AND over none is 1, OR over none is 0.
    all_hit = &(hit | ~en);
    any_hit = |(hit & en);
    match   = 1'b0;
    case (logic_op_e'(logic_op))
      LG_AND:  match =  all_hit;
      LG_OR:   match =  any_hit;
      LG_NAND: match = ~all_hit;
      LG_NOR:  match = ~any_hit;
      default: match =  1'b0;
    endcase
  end

endmodule

// File: rtl/trigger_seq_node.sv
// Multi-stage trigger sequencer driving a circular capture RAM.
//   trig_clk/trig_rstn : clock, async active-low reset
//   arm, pause         : start/restart capture, freeze capture
//   trig_din           : probe sample (registered once as d_q; RAM data is d_q)
//   stage_edge_mode, stage_logic, stage_count, num_stages, post_len : configuration
//   wt_ce, wt_en, wt_addr : RAM enable, write strobe, write address
//   stage_idx, trig_hit   : current stage, pulse on the trigger sample write
//   stop_flag, stop_addr  : capture complete, address of trigger sample
//   overflow_flag         : write address wrapped before stop
module trigger_seq_node
  import trig_pkg::*;
#(
  parameter int unsigned DET_NUM   = 19,
  parameter int unsigned STAGE_NUM = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                           trig_clk,
  input  logic                           trig_rstn,
  input  logic                           arm,
  input  logic                           pause,
  input  logic [DET_NUM-1:0]             trig_din,
  input  logic [STAGE_NUM*DET_NUM*3-1:0] stage_edge_mode,
  input  logic [STAGE_NUM*2-1:0]         stage_logic,
  input  logic [STAGE_NUM*CNT_W-1:0]     stage_count,
  input  logic [STAGE_IDX_W-1:0]         num_stages,
  input  logic [ADDR_W-1:0]              post_len,
  output logic                           wt_ce,
  output logic                           wt_en,
  output logic [ADDR_W-1:0]              wt_addr,
  output logic [STAGE_IDX_W-1:0]         stage_idx,
  output logic                           trig_hit,
  output logic                           stop_flag,
  output logic [ADDR_W-1:0]              stop_addr,
  output logic                           overflow_flag
);

  localparam logic [STAGE_IDX_W-1:0] LAST_MAX = STAGE_IDX_W'(STAGE_NUM - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
  localparam logic [ADDR_W-1:0]      ADDR_MAX = '1;

  state_e                 state, state_nx;
  logic [DET_NUM-1:0]     d_q, d_p;
  logic [CNT_W-1:0]       occ_cnt, occ_cnt_nx;
  logic [ADDR_W-1:0]      wt_addr_nx, stop_addr_nx;
  logic [ADDR_W-1:0]      post_left, post_left_nx;
  logic [STAGE_IDX_W-1:0] stage_idx_nx, last_stage;
  logic                   overflow_nx;
  logic [DET_NUM*3-1:0]   mode_sel;
  logic [1:0]             logic_sel;
  logic [CNT_W-1:0]       count_sel;
  logic                   match;
  logic                   active;

  assign last_stage = (num_stages > LAST_MAX) ? LAST_MAX : num_stages;

  // Route the current stage's configuration to the single evaluator.
  always_comb begin
    mode_sel  = '0;
    logic_sel = '0;
    count_sel = '0;
    for (int unsigned s = 0; s < STAGE_NUM; s++) begin
      if (32'(stage_idx) == s) begin
        mode_sel  = stage_edge_mode[s*DET_NUM*3 +: DET_NUM*3];
        logic_sel = stage_logic[s*2 +: 2];
        count_sel = stage_count[s*CNT_W +: CNT_W];
      end
    end
  end

  trig_stage_eval #(
    .DET_NUM (DET_NUM)
  ) u_eval (
    .d_q      (d_q),
    .d_p      (d_p),
    .mode     (mode_sel),
    .logic_op (logic_sel),
    .match    (match)
  );

  // A write of d_q happens this cycle; arm suppresses it so the cleared
  // address and counters start cleanly on the following cycle.
  assign active    = (state == ST_SEQ || state == ST_POST) && !pause && !arm;
  assign wt_ce     = active;
  assign wt_en     = active;
  assign stop_flag = (state == ST_DONE);

  always_comb begin
    state_nx     = state;
    stage_idx_nx = stage_idx;
    occ_cnt_nx   = occ_cnt;
    wt_addr_nx   = wt_addr;
    post_left_nx = post_left;
    stop_addr_nx = stop_addr;
    overflow_nx  = overflow_flag;
    trig_hit     = 1'b0;
    if (arm) begin
      state_nx     = ST_SEQ;
      stage_idx_nx = '0;
      occ_cnt_nx   = '0;
      wt_addr_nx   = '0;
      post_left_nx = '0;
      stop_addr_nx = '0;
      overflow_nx  = 1'b0;
    end else if (active) begin
      wt_addr_nx = wt_addr + 1'b1;
      if (wt_addr == ADDR_MAX) overflow_nx = 1'b1;
      case (state)
        ST_SEQ: begin
          if (match) begin
            if (occ_cnt == count_sel) begin
              occ_cnt_nx = '0;
              if (stage_idx >= last_stage) begin
                trig_hit     = 1'b1;
                stop_addr_nx = wt_addr;
                // post_len cannot exceed DEPTH-1 by width, so the trigger
                // sample is never overwritten.
                post_left_nx = post_len;
                state_nx     = (post_len == '0) ? ST_DONE : ST_POST;
              end else begin
                stage_idx_nx = stage_idx + 1'b1;
              end
            end else if (occ_cnt != CNT_MAX) begin
              occ_cnt_nx = occ_cnt + 1'b1;
            end
          end
        end
        ST_POST: begin
          post_left_nx = post_left - 1'b1;
          if (post_left == ADDR_W'(1)) state_nx = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge trig_clk or negedge trig_rstn) begin
    if (!trig_rstn) begin
      state         <= ST_IDLE;
      d_q           <= '0;
      d_p           <= '0;
      stage_idx     <= '0;
      occ_cnt       <= '0;
      wt_addr       <= '0;
      post_left     <= '0;
      stop_addr     <= '0;
      overflow_flag <= 1'b0;
    end else begin
      state         <= state_nx;
      d_q           <= trig_din;
      d_p           <= d_q;
      stage_idx     <= stage_idx_nx;
      occ_cnt       <= occ_cnt_nx;
      wt_addr       <= wt_addr_nx;
      post_left     <= post_left_nx;
      stop_addr     <= stop_addr_nx;
      overflow_flag <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_trigger_seq_node.sv
module tb_trigger_seq_node;

  localparam int DET   = 19;
  localparam int STG   = 4;
  localparam int AW    = 5;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  arm = 1'b0;
  logic                  pause = 1'b0;
  logic [DET-1:0]        trig_din = '0;
  logic [STG*DET*3-1:0]  stage_edge_mode = '0;
  logic [STG*2-1:0]      stage_logic = '0;
  logic [STG*CW-1:0]     stage_count = '0;
  logic [3:0]            num_stages = '0;
  logic [AW-1:0]         post_len = '0;
  logic                  wt_ce, wt_en, trig_hit, stop_flag, overflow_flag;
  logic [AW-1:0]         wt_addr, stop_addr;
  logic [3:0]            stage_idx;

  trigger_seq_node #(
    .DET_NUM   (DET),
    .STAGE_NUM (STG),
    .ADDR_W    (AW),
    .CNT_W     (CW)
  ) dut (
    .trig_clk        (clk),
    .trig_rstn       (rstn),
    .arm             (arm),
    .pause           (pause),
    .trig_din        (trig_din),
    .stage_edge_mode (stage_edge_mode),
    .stage_logic     (stage_logic),
    .stage_count     (stage_count),
    .num_stages      (num_stages),
    .post_len        (post_len),
    .wt_ce           (wt_ce),
    .wt_en           (wt_en),
    .wt_addr         (wt_addr),
    .stage_idx       (stage_idx),
    .trig_hit        (trig_hit),
    .stop_flag       (stop_flag),
    .stop_addr       (stop_addr),
    .overflow_flag   (overflow_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Configuration held by the bench as plain integers.
  int mode_c [STG][DET];
  int lg_c   [STG];
  int cnt_c  [STG];
  int nst_c;
  int plen_c;

  // v[j] is driven in cycle j of a run; j==1 is the arm cycle.
  // The write in post-arm cycle i stores sample v[i+1] with previous v[i].
  logic [DET-1:0] v  [0:201];
  bit             pz [0:199];

  typedef struct {int addr; int hit; int stg;} exp_t;
  exp_t sbq [$];
  bit   mon_on = 1'b0;

  task automatic clear_cfg();
    for (int s = 0; s < STG; s++) begin
      for (int b = 0; b < DET; b++) mode_c[s][b] = 0;
      lg_c[s]  = 0;
      cnt_c[s] = 0;
    end
    nst_c  = 0;
    plen_c = 0;
  endtask

  task automatic apply_cfg();
    for (int s = 0; s < STG; s++) begin
      for (int b = 0; b < DET; b++) stage_edge_mode[(s*DET+b)*3 +: 3] = 3'(mode_c[s][b]);
      stage_logic[s*2 +: 2]   = 2'(lg_c[s]);
      stage_count[s*CW +: CW] = 16'(cnt_c[s]);
    end
    num_stages = 4'(nst_c);
    post_len   = 5'(plen_c);
  endtask

  task automatic fill_base(input int n);
    for (int j = 0; j < n + 2; j++) v[j] = DET'($urandom);
    for (int i = 0; i < n; i++) pz[i] = 1'b0;
  endtask

  function automatic bit bit_hit(int m, bit cur, bit prv);
    case (m)
      1: return !cur;
      2: return cur;
      3: return cur && !prv;
      4: return !cur && prv;
      5: return cur != prv;
      default: return 1'b0;
    endcase
  endfunction

  // Counts enabled and satisfied bits, then applies the reduction rule.
  function automatic bit stage_match(int s, logic [DET-1:0] cur, logic [DET-1:0] prv);
    int n_en = 0;
    int n_hit = 0;
    for (int b = 0; b < DET; b++) begin
      if (mode_c[s][b] >= 1 && mode_c[s][b] <= 5) begin
        n_en++;
        if (bit_hit(mode_c[s][b], cur[b], prv[b])) n_hit++;
      end
    end
    case (lg_c[s])
      0: return n_hit == n_en;
      1: return n_hit > 0;
      2: return n_hit != n_en;
      default: return n_hit == 0;
    endcase
  endfunction

  task automatic run_capture(input int n);
    int   s = 0, occ = 0, nw = 0, phase = 0, left = 0, trig_a = -1, last;
    exp_t e;
    sbq.delete();
    last = (nst_c > STG - 1) ? STG - 1 : nst_c;
    for (int i = 0; i < n; i++) begin
      if (pz[i] || phase == 2) continue;
      e.addr = nw % DEPTH;
      e.stg  = s;
      e.hit  = 0;
      if (phase == 0) begin
        if (stage_match(s, v[i+1], v[i])) begin
          occ++;
          if (occ > cnt_c[s]) begin
            occ = 0;
            if (s == last) begin
              e.hit  = 1;
              trig_a = e.addr;
              left   = plen_c;
              phase  = (plen_c == 0) ? 2 : 1;
            end else begin
              s++;
            end
          end
        end
      end else begin
        left--;
        if (left == 0) phase = 2;
      end
      nw++;
      sbq.push_back(e);
    end

    apply_cfg();
    mon_on = 1'b0;
    for (int j = 0; j < n + 2; j++) begin
      trig_din = v[j];
      arm      = (j == 1);
      pause    = (j >= 2) ? pz[j-2] : 1'b0;
      if (j == 1) mon_on = 1'b1;
      if (j == 2) begin
        check("arm_wt_addr", int'(wt_addr), 0);
        check("arm_stage_idx", int'(stage_idx), 0);
        check("arm_stop_flag", int'(stop_flag), 0);
        check("arm_overflow", int'(overflow_flag), 0);
        check("arm_stop_addr", int'(stop_addr), 0);
      end
      @(posedge clk);
      #1;
    end
    arm    = 1'b0;
    pause  = 1'b0;
    mon_on = 1'b0;
    check("end_queue_empty", sbq.size(), 0);
    check("end_stop_flag", int'(stop_flag), (phase == 2) ? 1 : 0);
    check("end_stop_addr", int'(stop_addr), (trig_a < 0) ? 0 : trig_a);
    check("end_wt_addr", int'(wt_addr), nw % DEPTH);
    check("end_overflow", int'(overflow_flag), (nw >= DEPTH) ? 1 : 0);
    check("end_stage_idx", int'(stage_idx), s);
  endtask

  // Monitor: every write presented by the DUT consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t m;
    if (mon_on) begin
      check("ce_eq_en", int'(wt_ce), int'(wt_en));
      if (wt_en) begin
        if (sbq.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          m = sbq.pop_front();
          check("wr_addr", int'(wt_addr), m.addr);
          check("wr_trig_hit", int'(trig_hit), m.hit);
          check("wr_stage_idx", int'(stage_idx), m.stg);
        end
      end else begin
        check("hit_without_write", int'(trig_hit), 0);
      end
    end
  end

  task automatic check_all_zero(string tag);
    check({tag, "_wt_ce"}, int'(wt_ce), 0);
    check({tag, "_wt_en"}, int'(wt_en), 0);
    check({tag, "_wt_addr"}, int'(wt_addr), 0);
    check({tag, "_stage_idx"}, int'(stage_idx), 0);
    check({tag, "_trig_hit"}, int'(trig_hit), 0);
    check({tag, "_stop_flag"}, int'(stop_flag), 0);
    check({tag, "_stop_addr"}, int'(stop_addr), 0);
    check({tag, "_overflow"}, int'(overflow_flag), 0);
  endtask

  task automatic cfg_single_rise(input int plen);
    clear_cfg();
    mode_c[0][0] = 3;
    plen_c       = plen;
  endtask

  initial begin
    clear_cfg();
    apply_cfg();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single stage rise on bit0 at sample 20, eight post-trigger writes.
    cfg_single_rise(8);
    fill_base(40);
    for (int j = 0; j < 42; j++) v[j][0] = (j >= 21);
    run_capture(40);

    // Three stages in the intended order.
    clear_cfg();
    mode_c[0][1] = 2; cnt_c[0] = 2;
    mode_c[1][2] = 4; cnt_c[1] = 0;
    mode_c[2][3] = 2; mode_c[2][4] = 2; lg_c[2] = 1; cnt_c[2] = 0;
    nst_c = 2; plen_c = 4;
    fill_base(30);
    for (int j = 0; j < 32; j++) begin
      v[j][4:1] = '0;
      v[j][2]   = (j >= 1 && j <= 10);
      v[j][1]   = (j == 4 || j == 6 || j == 8);
      v[j][3]   = (j == 15);
    end
    run_capture(30);

    // Same stages, events in the wrong order: no trigger.
    fill_base(30);
    for (int j = 0; j < 32; j++) begin
      v[j][4:1] = '0;
      v[j][2]   = (j >= 1 && j <= 2);
      v[j][3]   = (j == 5);
      v[j][1]   = (j == 7 || j == 9 || j == 11);
    end
    run_capture(30);

    // Trigger at sample 40 after the buffer wrapped; maximum post length.
    cfg_single_rise(31);
    fill_base(80);
    for (int j = 0; j < 82; j++) v[j][0] = (j >= 41);
    run_capture(80);

    // Pause across a rise that stays high: the edge is never seen.
    cfg_single_rise(4);
    fill_base(30);
    for (int j = 0; j < 32; j++) v[j][0] = (j >= 11);
    for (int i = 9; i <= 13; i++) pz[i] = 1'b1;
    run_capture(30);

    // Stop inside POST, then re-arm while still posting.
    cfg_single_rise(20);
    fill_base(26);
    for (int j = 0; j < 28; j++) v[j][0] = (j >= 21);
    run_capture(26);
    cfg_single_rise(8);
    fill_base(40);
    for (int j = 0; j < 42; j++) v[j][0] = (j >= 21);
    run_capture(40);

    // Asynchronous reset while in POST, then idle until armed.
    cfg_single_rise(20);
    fill_base(26);
    for (int j = 0; j < 28; j++) v[j][0] = (j >= 21);
    run_capture(26);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("mid_post_reset");
    @(negedge clk);
    rstn = 1'b1;
    sbq.delete();
    mon_on = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    mon_on = 1'b0;
    check("idle_after_reset_stop_flag", int'(stop_flag), 0);
    check("idle_after_reset_wt_addr", int'(wt_addr), 0);

    // Randomized configurations, samples and pauses.
    for (int r = 0; r < 6; r++) begin
      clear_cfg();
      for (int s = 0; s < STG; s++) begin
        for (int b = 0; b < DET; b++)
          mode_c[s][b] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
        lg_c[s]  = int'($urandom_range(0, 3));
        cnt_c[s] = int'($urandom_range(0, 3));
      end
      nst_c  = int'($urandom_range(0, 5));
      plen_c = int'($urandom_range(0, DEPTH - 1));
      fill_base(80);
      for (int i = 0; i < 80; i++) pz[i] = ($urandom_range(0, 4) == 0);
      run_capture(80);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
